alu_issue_ctrl: RTL



---
 rtl/alu_issue_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decode / issue / writeback sequencer around an external ALU.
// Takes one 32-bit MIPS-style instruction per handshake, reads operands from an
// internal register file (r0 reads as zero), drives registered a/b/funct to the
// ALU, then writes the ALU's registered result back to the destination register.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   instr_valid/instr upstream instruction handshake (input side)
//   instr_ready       high only while idle
//   alu_a/alu_b       registered ALU operands
//   alu_funct         registered ALU function code
//   alu_result        registered result coming back from the ALU
//   wb_valid/addr/data writeback strobe, destination and data (WB cycle only)
//   illegal           one-cycle pulse after an undecodable instruction
//   dbg_addr/dbg_data combinational debug read of the register file
//   instr_count       number of completed writebacks (wraps)
module alu_issue_ctrl #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [5:0]       alu_funct,
  input  logic [31:0]      alu_result,
  output logic             wb_valid,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic             illegal,
  input  logic [4:0]       dbg_addr,
  output logic [31:0]      dbg_data,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_e;

  state_e             state_q, state_d;
  logic [31:0]        alu_a_q, alu_a_d;
  logic [31:0]        alu_b_q, alu_b_d;
  logic [5:0]         alu_funct_q, alu_funct_d;
  logic [4:0]         dest_q, dest_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic [31:0]        regs_q [NREGS];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        dec_legal;
  logic [31:0] dec_a, dec_b;
  logic [5:0]  dec_funct;
  logic [4:0]  dec_dest;
  logic        handshake;
  logic        wr_en;

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign imm    = instr[15:0];
  assign funct  = instr[5:0];

  // Decode: r0 is never written, so regs_q[0] already reads as zero.
  always_comb begin
    dec_legal = 1'b0;
    dec_a     = regs_q[rs];
    dec_b     = '0;
    dec_funct = '0;
    dec_dest  = rt;
    if (opcode == 6'h00) begin
      dec_legal = (funct <= 6'h08);
      dec_b     = regs_q[rt];
      dec_funct = funct;
      dec_dest  = rd;
    end else begin
      unique case (opcode)
        6'h08: begin dec_legal = 1'b1; dec_funct = 6'h00; dec_b = {{16{imm[15]}}, imm}; end
        6'h09: begin dec_legal = 1'b1; dec_funct = 6'h02; dec_b = {{16{imm[15]}}, imm}; end
        6'h0C: begin dec_legal = 1'b1; dec_funct = 6'h04; dec_b = {16'h0000, imm}; end
        6'h0D: begin dec_legal = 1'b1; dec_funct = 6'h05; dec_b = {16'h0000, imm}; end
        6'h0B: begin dec_legal = 1'b1; dec_funct = 6'h08; dec_b = {{16{imm[15]}}, imm}; end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  // State register plus all datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_funct_q   <= '0;
      dest_q        <= '0;
      illegal_q     <= 1'b0;
      instr_count_q <= '0;
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_funct_q   <= alu_funct_d;
      dest_q        <= dest_d;
      illegal_q     <= illegal_d;
      instr_count_q <= instr_count_d;
      if (wr_en) regs_q[dest_q] <= alu_result;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (instr_valid && dec_legal) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operands only load on a legal handshake, so an
  // illegal instruction leaves the ALU inputs untouched.
  always_comb begin
    handshake     = (state_q == S_IDLE) && instr_valid;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_funct_d   = alu_funct_q;
    dest_d        = dest_q;
    illegal_d     = handshake && !dec_legal;
    instr_count_d = instr_count_q;
    wr_en         = 1'b0;
    if (handshake && dec_legal) begin
      alu_a_d     = dec_a;
      alu_b_d     = dec_b;
      alu_funct_d = dec_funct;
      dest_d      = dec_dest;
    end
    if (state_q == S_WB) begin
      wr_en         = (dest_q != 5'd0);
      instr_count_d = instr_count_q + CNT_W'(1);
    end
  end

  // Outputs.
  always_comb begin
    instr_ready = (state_q == S_IDLE);
    wb_valid    = (state_q == S_WB);
    wb_addr     = '0;
    wb_data     = '0;
    if (state_q == S_WB) begin
      wb_addr = dest_q;
      wb_data = alu_result;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_funct   = alu_funct_q;
  assign illegal     = illegal_q;
  assign instr_count = instr_count_q;
  assign dbg_data    = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule
